db15_joy_responder: RTL
=======================

# db15_joy_responder

Cycle-accurate emulation of the two-player DB15 serial joystick adapter: the device end of the JOY_LOAD / JOY_CLK / JOY_DATA shift-register protocol driven by the core's DB15 reader. The block latches two 12-bit button/direction words on a load strobe and presents them bit-serially on JOY_DATA, advancing one bit per rising JOY_CLK edge, with the same active-low semantics as the adapter's cascaded parallel-in/serial-out chain. It is used for loopback self-test of the SNAC path and as the stimulus model in core-level simulation. It runs on clk_sys (48 MHz).

## Interface
- W, 12: bits per player; frame length NBITS = 2*W.
- clk  in  1  system clock (clk_sys).
- reset  in  1  synchronous, active-high reset.
- joy1  in  W  player-1 state, 1 = pressed; bit 0 = right, 1 = left, 2 = down, 3 = up, 4.. = buttons.
- joy2  in  W  player-2 state, same layout.
- JOY_CLK  in  1  shift clock from the reader, asynchronous to clk.
- JOY_LOAD  in  1  parallel-load strobe, active low, asynchronous to clk.
- JOY_DATA  out  1  serial data, active low (0 = pressed).
- frame_done  out  1  one-cycle pulse when the last frame bit goes onto JOY_DATA.
- bit_idx  out  5  index of the bit currently on JOY_DATA; NBITS = exhausted.

## Operation
- Synchronise JOY_CLK and JOY_LOAD through two flops each. Synchroniser reset value is 1 (idle-high line).
- frame = {joy2, joy1}. Frame bit k is frame[k]; bit 0 (joy1[0]) is shifted out first.
- States:
  - IDLE: after reset. JOY_DATA = 1, bit_idx = NBITS. JOY_CLK edges are ignored.
  - LOAD: synced LOAD = 0.
    - Every cycle, load the shift register with ~frame (transparent load, as on a 74165).
    - JOY_DATA = ~frame[0]; bit_idx = 0.
    - Clock edges are ignored.
    - On synced LOAD rising, go to SHIFT.
  - SHIFT: each synced JOY_CLK rising edge (prev 0, now 1) does the following.
    - Shift right, filling the register with 1 (serial-in tied high).
    - Advance bit_idx, saturating at NBITS.
    - JOY_DATA = the new LSB.
    - When bit_idx reaches NBITS, JOY_DATA stays 1. Further edges are ignored apart from keeping JOY_DATA high.
    - A synced LOAD fall goes to LOAD from any state.
- frame_done pulses on the edge that makes bit_idx = NBITS-1. It pulses at most once per load.
- joy1/joy2 are sampled only while in LOAD. Changes during SHIFT do not affect the frame in flight.
- Simultaneous events: if the synced LOAD fall and the JOY_CLK rise land in the same cycle, the load wins and no shift occurs.
- Reset mid-frame: all state returns to reset values. Output stays 1 until the next LOAD.

## Timing
- Reset values: JOY_DATA = 1, frame_done = 0, bit_idx = NBITS, shift register all 1, state IDLE.
- Latency: pin edge (LOAD fall or CLK rise) to JOY_DATA / bit_idx update is 3 clk cycles (2 sync + 1 register).
- The reader must therefore sample JOY_DATA at least 4 clk cycles after its own CLK rise or LOAD release.
- Minimum pulse widths: JOY_CLK high and low ≥ 3 clk cycles each; JOY_LOAD low ≥ 3 cycles. Shorter pulses may be missed, which is legal behaviour.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset with all inputs idle high → JOY_DATA = 1, bit_idx = 24, frame_done = 0; 10 JOY_CLK pulses with no load → JOY_DATA stays 1.
- joy1 = 12'h001, joy2 = 0; LOAD low 4 cycles then high; 23 JOY_CLK pulses, each 4 cycles high and 4 low → bit 0 reads 0, bits 1-23 read 1; frame_done pulses exactly once, on the 23rd edge.
- joy1 = 0, joy2 = 12'h800; full frame → only bit 23 = 0; 5 extra clocks → JOY_DATA = 1, bit_idx = 24, no second frame_done.
- joy1 = 12'hA5A; load, 6 shifts, then re-load with joy1 = 12'h0F0 → bit_idx returns to 0; new frame serialises ~12'h0F0 from bit 0.
- Change joy1 from 0 to 12'hFFF mid-frame after the load → remaining bits still read 1.
- Assert reset at bit_idx = 10 → next cycle JOY_DATA = 1, bit_idx = 24; further JOY_CLK pulses are ignored until LOAD.
- LOAD fall and JOY_CLK rise presented in the same clk cycle → bit_idx = 0 and no shift.
- 2-cycle JOY_CLK high glitch → is either shifted cleanly or ignored; JOY_DATA never changes more than once per edge.

Source files
------------

// File: rtl/db15_joy_responder.sv
// Device end of the two-player DB15 joystick shift chain: latches {joy2,joy1}
// on JOY_LOAD low and shifts it out active-low on JOY_DATA per JOY_CLK rise.
//
// Ports:
//   clk, reset         system clock (clk_sys) and synchronous active-high reset
//   joy1, joy2         player state, 1 = pressed (bit0 right .. bit3 up, buttons)
//   JOY_CLK, JOY_LOAD  reader shift clock / active-low load, async to clk
//   JOY_DATA           serial data, active low, registered
//   frame_done         one-cycle pulse when the last frame bit is presented
//   bit_idx            index of the bit on JOY_DATA, 2*W when exhausted

module db15_joy_responder #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] joy1,
  input  logic [W-1:0] joy2,
  input  logic         JOY_CLK,
  input  logic         JOY_LOAD,
  output logic         JOY_DATA,
  output logic         frame_done,
  output logic [4:0]   bit_idx
);

  localparam int NBITS = 2 * W;
  localparam logic [4:0] NB    = 5'(NBITS);
  localparam logic [4:0] NB_M2 = 5'(NBITS - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Two-flop synchronisers plus one history flop for edge detection.
  logic clk_s1_q, clk_s2_q, clk_s3_q;
  logic ld_s1_q, ld_s2_q;

  logic [NBITS-1:0] sr_q, sr_d;
  logic [4:0]       idx_q, idx_d;
  logic             done_q, done_d;

  logic             clk_rise;
  logic [NBITS-1:0] frame;

  assign frame    = {joy2, joy1};
  assign clk_rise = clk_s2_q & ~clk_s3_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      clk_s3_q <= 1'b1;
      ld_s1_q  <= 1'b1;
      ld_s2_q  <= 1'b1;
    end else begin
      clk_s1_q <= JOY_CLK;
      clk_s2_q <= clk_s1_q;
      clk_s3_q <= clk_s2_q;
      ld_s1_q  <= JOY_LOAD;
      ld_s2_q  <= ld_s1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '1;
      idx_q   <= NB;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Load has priority over any coincident clock edge; while load is held
  // the register follows the inputs like a transparent 74165 load.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    if (!ld_s2_q) begin
      state_d = LOAD;
      sr_d    = ~frame;
      idx_d   = 5'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        LOAD: begin
          state_d = SHIFT;
        end
        SHIFT: begin
          if (clk_rise && (idx_q < NB)) begin
            sr_d   = {1'b1, sr_q[NBITS-1:1]};
            idx_d  = idx_q + 5'd1;
            done_d = (idx_q == NB_M2);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // After the last shift the register is all ones, so the line idles high.
  assign JOY_DATA   = sr_q[0];
  assign frame_done = done_q;
  assign bit_idx    = idx_q;

endmodule
